// File: rtl/pipeline_sequencer_if.sv
// Front-end bundle between the fetch side, the sequencer and its observers.
// The master drives fetch/branch inputs; the slave (sequencer) drives the
// decode history, PC enable, status and event counters.
interface pipeline_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [15:0]      instr_in;
  logic             branch_taken;
  logic             pc_en;
  logic [15:0]      COMMAND;
  logic [15:0]      BeforeCOMMAND;
  logic [15:0]      TwoBeforeCOMMAND;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output start, instr_in, branch_taken,
    input  pc_en, COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND,
    input  busy, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  start, instr_in, branch_taken,
    output pc_en, COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND,
    output busy, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Front-end pipeline sequencer for the 16-bit core: owns the three-deep
// instruction history feeding decode, drives the PC enable and injects
// bubbles for load-use stalls, taken-branch flushes and HLT drain.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; history frozen, PC held
//   RUN     | normal fetch; one shift per cycle, load-use stall possible
//   FLUSH   | post-branch bubbles; PC advances, down-counter runs
//   DRAIN   | HLT in flight; bubbles shift in, PC held
//   HALTED  | HLT reached TwoBeforeCOMMAND; frozen until reset
module pipeline_sequencer #(
  parameter int          FLUSH_DEPTH = 2,
  parameter int          CNT_W       = 16,
  parameter logic [15:0] BUBBLE      = 16'hC0E0
) (
  input logic                clk,
  input logic                rst,
  pipeline_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_FLUSH  = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_DEPTH - 1);

  state_t           state_q, state_d;
  logic [15:0]      cmd_q, cmd_d;
  logic [15:0]      bef_q, bef_d;
  logic [15:0]      two_q, two_d;
  logic [1:0]       dcnt_q, dcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic             pc_en_c;
  logic             shift_c;
  logic [15:0]      next_word_c;
  logic             active_c;
  logic             is_hlt_c;
  logic             hazard_c;

  // Decode of the fetched word against the instruction currently in decode.
  always_comb begin
    is_hlt_c = (bus.instr_in[15:14] == 2'b11) && (bus.instr_in[7:4] == 4'b1111);
    hazard_c = (cmd_q[15:14] == 2'b00)
            && ((bus.instr_in[15:14] == 2'b11) || (bus.instr_in[15:14] == 2'b01))
            && ((bus.instr_in[10:8] == cmd_q[13:11]) || (bus.instr_in[13:11] == cmd_q[13:11]));
    active_c = (state_q == S_RUN) || (state_q == S_FLUSH) || (state_q == S_DRAIN);
  end

  // Next-state, history shift, counters and PC enable.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    bef_d       = bef_q;
    two_d       = two_q;
    dcnt_d      = dcnt_q;
    stall_d     = stall_q;
    flush_d     = flush_q;
    pc_en_c     = 1'b0;
    shift_c     = 1'b0;
    next_word_c = BUBBLE;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        shift_c     = 1'b1;
        pc_en_c     = 1'b1;
        next_word_c = bus.instr_in;
        if (is_hlt_c) begin
          // HLT itself enters decode; the PC is frozen from this cycle on.
          state_d = S_DRAIN;
          pc_en_c = 1'b0;
          dcnt_d  = 2'd1;
        end else if (hazard_c) begin
          // Hold the PC one cycle; the same word re-presents and then
          // compares against the bubble, so the stall never repeats.
          next_word_c = BUBBLE;
          pc_en_c     = 1'b0;
          stall_d     = (&stall_q) ? stall_q : stall_q + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        shift_c = 1'b1;
        pc_en_c = 1'b1;
        if (dcnt_q <= 2'd1) begin
          dcnt_d  = 2'd0;
          state_d = S_RUN;
        end else begin
          dcnt_d = dcnt_q - 2'd1;
        end
      end
      S_DRAIN: begin
        shift_c = 1'b1;
        if (dcnt_q == 2'd0) begin
          state_d = S_HALTED;
        end else begin
          dcnt_d = dcnt_q - 2'd1;
        end
      end
      S_HALTED: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A taken branch outranks HLT and stall handling in every live state;
    // it also squashes an HLT still draining.
    if (active_c && bus.branch_taken) begin
      shift_c     = 1'b1;
      next_word_c = BUBBLE;
      pc_en_c     = 1'b1;
      stall_d     = stall_q;
      flush_d     = (&flush_q) ? flush_q : flush_q + CNT_W'(1);
      dcnt_d      = FLUSH_RELOAD;
      state_d     = (FLUSH_DEPTH == 1) ? S_RUN : S_FLUSH;
    end

    if (shift_c) begin
      two_d = bef_q;
      bef_d = cmd_q;
      cmd_d = next_word_c;
    end
  end

  // State, history and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= BUBBLE;
      bef_q   <= BUBBLE;
      two_q   <= BUBBLE;
      dcnt_q  <= 2'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      bef_q   <= bef_d;
      two_q   <= two_d;
      dcnt_q  <= dcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_en            = pc_en_c;
  assign bus.COMMAND          = cmd_q;
  assign bus.BeforeCOMMAND    = bef_q;
  assign bus.TwoBeforeCOMMAND = two_q;
  assign bus.busy             = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign bus.halted           = (state_q == S_HALTED);
  assign bus.stall_cnt        = stall_q;
  assign bus.flush_cnt        = flush_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer with FLUSH_DEPTH=2.
module tb_pipeline_sequencer;
  localparam logic [15:0] BUB = 16'hC0E0;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipeline_sequencer_if #(.CNT_W(16)) bus ();

  pipeline_sequencer #(
    .FLUSH_DEPTH(2),
    .CNT_W(16),
    .BUBBLE(16'hC0E0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] w, input logic br);
    bus.instr_in     = w;
    bus.branch_taken = br;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    drive(16'h0000, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.COMMAND !== BUB) begin failures++; $display("FAIL reset_cmd got=%h exp=%h", bus.COMMAND, BUB); end
    checks++; if (bus.BeforeCOMMAND !== BUB) begin failures++; $display("FAIL reset_bef got=%h exp=%h", bus.BeforeCOMMAND, BUB); end
    checks++; if (bus.TwoBeforeCOMMAND !== BUB) begin failures++; $display("FAIL reset_two got=%h exp=%h", bus.TwoBeforeCOMMAND, BUB); end
    checks++; if (bus.pc_en !== 1'b0) begin failures++; $display("FAIL reset_pc_en got=%b exp=0", bus.pc_en); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    checks++; if (bus.stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cnt); end
    checks++; if (bus.flush_cnt !== 16'd0) begin failures++; $display("FAIL reset_flush got=%0d exp=0", bus.flush_cnt); end
    // IDLE ignores fetch and branch
    drive(16'hC100, 1'b1);
    tick();
    checks++; if (bus.COMMAND !== BUB) begin failures++; $display("FAIL idle_noshift got=%h exp=%h", bus.COMMAND, BUB); end
    checks++; if (bus.flush_cnt !== 16'd0) begin failures++; $display("FAIL idle_flush got=%0d exp=0", bus.flush_cnt); end
  endtask

  task automatic test_stream();
    logic [15:0] w;
    logic [15:0] eb;
    logic [15:0] et;
    drive(16'hC100, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%b exp=1", bus.busy); end
    for (int i = 0; i < 5; i++) begin
      w  = 16'hC100 + 16'(i);
      eb = (i >= 1) ? w - 16'd1 : BUB;
      et = (i >= 2) ? w - 16'd2 : BUB;
      drive(w, 1'b0);
      checks++; if (bus.pc_en !== 1'b1) begin failures++; $display("FAIL stream_pc_en[%0d] got=%b exp=1", i, bus.pc_en); end
      tick();
      checks++; if (bus.COMMAND !== w) begin failures++; $display("FAIL stream_cmd[%0d] got=%h exp=%h", i, bus.COMMAND, w); end
      checks++; if (bus.BeforeCOMMAND !== eb) begin failures++; $display("FAIL stream_bef[%0d] got=%h exp=%h", i, bus.BeforeCOMMAND, eb); end
      checks++; if (bus.TwoBeforeCOMMAND !== et) begin failures++; $display("FAIL stream_two[%0d] got=%h exp=%h", i, bus.TwoBeforeCOMMAND, et); end
    end
    checks++; if (bus.stall_cnt !== 16'd0) begin failures++; $display("FAIL stream_stall got=%0d exp=0", bus.stall_cnt); end
  endtask

  task automatic test_load_use();
    drive(16'h1100, 1'b0);
    tick();
    checks++; if (bus.COMMAND !== 16'h1100) begin failures++; $display("FAIL ld_cmd got=%h exp=1100", bus.COMMAND); end
    drive(16'hC200, 1'b0);
    checks++; if (bus.pc_en !== 1'b0) begin failures++; $display("FAIL lu_pc_en got=%b exp=0", bus.pc_en); end
    tick();
    checks++; if (bus.COMMAND !== BUB) begin failures++; $display("FAIL lu_bubble got=%h exp=%h", bus.COMMAND, BUB); end
    checks++; if (bus.BeforeCOMMAND !== 16'h1100) begin failures++; $display("FAIL lu_bef got=%h exp=1100", bus.BeforeCOMMAND); end
    checks++; if (bus.stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_stall got=%0d exp=1", bus.stall_cnt); end
    checks++; if (bus.pc_en !== 1'b1) begin failures++; $display("FAIL lu_resume_pc_en got=%b exp=1", bus.pc_en); end
    tick();
    checks++; if (bus.COMMAND !== 16'hC200) begin failures++; $display("FAIL lu_enter got=%h exp=c200", bus.COMMAND); end
    checks++; if (bus.TwoBeforeCOMMAND !== 16'h1100) begin failures++; $display("FAIL lu_two got=%h exp=1100", bus.TwoBeforeCOMMAND); end
    checks++; if (bus.stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_single got=%0d exp=1", bus.stall_cnt); end
  endtask

  task automatic test_hazard_boundary();
    // LD r2 then ALU ra=1 rb=3: no dependency
    drive(16'h1100, 1'b0);
    tick();
    drive(16'hCB00, 1'b0);
    checks++; if (bus.pc_en !== 1'b1) begin failures++; $display("FAIL nodep_pc_en got=%b exp=1", bus.pc_en); end
    tick();
    checks++; if (bus.COMMAND !== 16'hCB00) begin failures++; $display("FAIL nodep_cmd got=%h exp=cb00", bus.COMMAND); end
    // class 10 reading r2 never stalls
    drive(16'h1100, 1'b0);
    tick();
    drive(16'h9200, 1'b0);
    checks++; if (bus.pc_en !== 1'b1) begin failures++; $display("FAIL class10_pc_en got=%b exp=1", bus.pc_en); end
    tick();
    checks++; if (bus.COMMAND !== 16'h9200) begin failures++; $display("FAIL class10_cmd got=%h exp=9200", bus.COMMAND); end
    checks++; if (bus.stall_cnt !== 16'd1) begin failures++; $display("FAIL nodep_stall got=%0d exp=1", bus.stall_cnt); end
    // class 01 matching on bits 13:11 does stall
    drive(16'h1100, 1'b0);
    tick();
    drive(16'h5000, 1'b0);
    checks++; if (bus.pc_en !== 1'b0) begin failures++; $display("FAIL class01_pc_en got=%b exp=0", bus.pc_en); end
    tick();
    checks++; if (bus.COMMAND !== BUB) begin failures++; $display("FAIL class01_bubble got=%h exp=%h", bus.COMMAND, BUB); end
    checks++; if (bus.stall_cnt !== 16'd2) begin failures++; $display("FAIL class01_stall got=%0d exp=2", bus.stall_cnt); end
    tick();
    checks++; if (bus.COMMAND !== 16'h5000) begin failures++; $display("FAIL class01_enter got=%h exp=5000", bus.COMMAND); end
  endtask

  task automatic test_flush();
    drive(16'hC300, 1'b1);
    checks++; if (bus.pc_en !== 1'b1) begin failures++; $display("FAIL br_pc_en got=%b exp=1", bus.pc_en); end
    tick();
    checks++; if (bus.COMMAND !== BUB) begin failures++; $display("FAIL br_bub1 got=%h exp=%h", bus.COMMAND, BUB); end
    checks++; if (bus.BeforeCOMMAND !== 16'h5000) begin failures++; $display("FAIL br_bef got=%h exp=5000", bus.BeforeCOMMAND); end
    checks++; if (bus.flush_cnt !== 16'd1) begin failures++; $display("FAIL br_flush1 got=%0d exp=1", bus.flush_cnt); end
    drive(16'hC301, 1'b0);
    checks++; if (bus.pc_en !== 1'b1) begin failures++; $display("FAIL flush_pc_en got=%b exp=1", bus.pc_en); end
    tick();
    checks++; if (bus.COMMAND !== BUB) begin failures++; $display("FAIL br_bub2 got=%h exp=%h", bus.COMMAND, BUB); end
    checks++; if (bus.BeforeCOMMAND !== BUB) begin failures++; $display("FAIL br_bub2_bef got=%h exp=%h", bus.BeforeCOMMAND, BUB); end
    drive(16'hC302, 1'b0);
    tick();
    checks++; if (bus.COMMAND !== 16'hC302) begin failures++; $display("FAIL br_resume got=%h exp=c302", bus.COMMAND); end
    // second branch, re-triggered on the following flush cycle
    drive(16'hC303, 1'b1);
    tick();
    checks++; if (bus.flush_cnt !== 16'd2) begin failures++; $display("FAIL br_flush2 got=%0d exp=2", bus.flush_cnt); end
    drive(16'hC304, 1'b1);
    checks++; if (bus.pc_en !== 1'b1) begin failures++; $display("FAIL rebr_pc_en got=%b exp=1", bus.pc_en); end
    tick();
    checks++; if (bus.COMMAND !== BUB) begin failures++; $display("FAIL rebr_bub got=%h exp=%h", bus.COMMAND, BUB); end
    checks++; if (bus.flush_cnt !== 16'd3) begin failures++; $display("FAIL rebr_flush3 got=%0d exp=3", bus.flush_cnt); end
    drive(16'hC305, 1'b0);
    tick();
    checks++; if (bus.COMMAND !== BUB) begin failures++; $display("FAIL rebr_bub2 got=%h exp=%h", bus.COMMAND, BUB); end
    drive(16'hC306, 1'b0);
    tick();
    checks++; if (bus.COMMAND !== 16'hC306) begin failures++; $display("FAIL rebr_resume got=%h exp=c306", bus.COMMAND); end
  endtask

  task automatic test_halt();
    drive(16'hC0F0, 1'b0);
    checks++; if (bus.pc_en !== 1'b0) begin failures++; $display("FAIL hlt_pc_en got=%b exp=0", bus.pc_en); end
    tick();
    checks++; if (bus.COMMAND !== 16'hC0F0) begin failures++; $display("FAIL hlt_cmd got=%h exp=c0f0", bus.COMMAND); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL hlt_busy got=%b exp=1", bus.busy); end
    drive(16'hC400, 1'b0);
    checks++; if (bus.pc_en !== 1'b0) begin failures++; $display("FAIL drain_pc_en got=%b exp=0", bus.pc_en); end
    tick();
    checks++; if (bus.BeforeCOMMAND !== 16'hC0F0) begin failures++; $display("FAIL drain_bef got=%h exp=c0f0", bus.BeforeCOMMAND); end
    checks++; if (bus.COMMAND !== BUB) begin failures++; $display("FAIL drain_cmd got=%h exp=%h", bus.COMMAND, BUB); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL drain_halted got=%b exp=0", bus.halted); end
    tick();
    checks++; if (bus.TwoBeforeCOMMAND !== 16'hC0F0) begin failures++; $display("FAIL halt_two got=%h exp=c0f0", bus.TwoBeforeCOMMAND); end
    checks++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL halt_halted got=%b exp=1", bus.halted); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL halt_busy got=%b exp=0", bus.busy); end
    drive(16'hC500, 1'b1);
    checks++; if (bus.pc_en !== 1'b0) begin failures++; $display("FAIL halted_pc_en got=%b exp=0", bus.pc_en); end
    tick();
    tick();
    checks++; if (bus.TwoBeforeCOMMAND !== 16'hC0F0) begin failures++; $display("FAIL halted_frozen got=%h exp=c0f0", bus.TwoBeforeCOMMAND); end
    checks++; if (bus.COMMAND !== BUB) begin failures++; $display("FAIL halted_cmd got=%h exp=%h", bus.COMMAND, BUB); end
    checks++; if (bus.flush_cnt !== 16'd3) begin failures++; $display("FAIL halted_flush got=%0d exp=3", bus.flush_cnt); end
    checks++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL halted_stays got=%b exp=1", bus.halted); end
  endtask

  task automatic test_drain_cancel();
    rst = 1'b1;
    drive(16'hC100, 1'b0);
    tick();
    rst = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++; if (bus.COMMAND !== 16'hC100) begin failures++; $display("FAIL dc_first got=%h exp=c100", bus.COMMAND); end
    drive(16'hC0F0, 1'b0);
    tick();
    drive(16'hC600, 1'b1);
    checks++; if (bus.pc_en !== 1'b1) begin failures++; $display("FAIL dc_pc_en got=%b exp=1", bus.pc_en); end
    tick();
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL dc_halted got=%b exp=0", bus.halted); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL dc_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.COMMAND !== BUB) begin failures++; $display("FAIL dc_cmd got=%h exp=%h", bus.COMMAND, BUB); end
    checks++; if (bus.flush_cnt !== 16'd1) begin failures++; $display("FAIL dc_flush got=%0d exp=1", bus.flush_cnt); end
    drive(16'hC601, 1'b0);
    checks++; if (bus.pc_en !== 1'b1) begin failures++; $display("FAIL dc_flush_pc_en got=%b exp=1", bus.pc_en); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.COMMAND !== BUB) begin failures++; $display("FAIL mrst_cmd got=%h exp=%h", bus.COMMAND, BUB); end
    checks++; if (bus.BeforeCOMMAND !== BUB) begin failures++; $display("FAIL mrst_bef got=%h exp=%h", bus.BeforeCOMMAND, BUB); end
    checks++; if (bus.TwoBeforeCOMMAND !== BUB) begin failures++; $display("FAIL mrst_two got=%h exp=%h", bus.TwoBeforeCOMMAND, BUB); end
    checks++; if (bus.flush_cnt !== 16'd0) begin failures++; $display("FAIL mrst_flush got=%0d exp=0", bus.flush_cnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.pc_en !== 1'b0) begin failures++; $display("FAIL mrst_pc_en got=%b exp=0", bus.pc_en); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "time limit expired");
  end

  initial begin
    bus.start        = 1'b0;
    bus.instr_in     = 16'h0000;
    bus.branch_taken = 1'b0;
    rst              = 1'b1;
    test_reset();
    test_stream();
    test_load_use();
    test_hazard_boundary();
    test_flush();
    test_halt();
    test_drain_cancel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
